bank_request_scheduler: RTL and testbench
=========================================

Name: bank_request_scheduler

Overview:
Shares the NB interleaved memory banks among NREQ requesters. Each cycle the block:
- splits every requester's global address into bank select (low BANK_BITS) and local address (global_addr >> BANK_BITS);
- runs an independent round-robin arbiter per bank;
- issues at most one registered command per bank;
- routes 1-cycle-latency bank read data back to the winning requester.

It sits between the systolic-array/DMA requesters and the bank SRAM macros.

Parameters:
ADDR_W, ADDR_WIDTH (16), global address width
NB, NUM_BANKS (4), number of banks; power of two; BANK_BITS = log2(NB)
NREQ, 4, number of requesters
DATA_W, 16, data word width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a pending access
req_ready  out  NREQ  requester i accepted this cycle (combinational)
req_we  in  NREQ  1=write, 0=read
req_addr  in  NREQ*ADDR_W  global addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  write data
rsp_valid  out  NREQ  read data valid for requester i
rsp_rdata  out  NREQ*DATA_W  read data
bank_en  out  NB  bank command strobe (registered)
bank_we  out  NB  bank write enable (registered)
bank_addr  out  NB*ADDR_W  local address per bank (registered, upper BANK_BITS zero)
bank_wdata  out  NB*DATA_W  bank write data (registered)
bank_rdata  in  NB*DATA_W  bank read data, valid 1 cycle after bank_en&!bank_we
conflict_cnt  out  32  count of cycles with ≥1 valid requester not granted

Behaviour:
- Reset (async, rst_n=0): bank_en, bank_we, rsp_valid = 0; bank_addr, bank_wdata, rsp_rdata = 0; all rr_ptr = 0; conflict_cnt = 0; pending-read tags cleared. req_ready is 0 while in reset.
- Decode (combinational): for each requester, sel_i = req_addr_i[BANK_BITS-1:0]; loc_i = req_addr_i >> BANK_BITS.
- Arbitration per bank b:
  - Candidates are requesters with req_valid & sel_i==b.
  - Winner is the first candidate scanning i = rr_ptr[b], rr_ptr[b]+1, … mod NREQ.
  - req_ready_i = 1 iff i won its bank. A requester cannot win twice, since it targets exactly one bank.
- Handshake: transfer occurs on req_valid & req_ready. req_ready must not depend on its own past ready. Requesters hold addr/we/wdata stable until accepted.
- rr_ptr[b] update: on a grant to w, rr_ptr[b] <= (w+1) mod NREQ. With no grant, rr_ptr[b] holds.
- Issue (cycle T = accept cycle): at T+1, bank_en[b]=1, bank_we[b]=req_we_w, bank_addr[b]=loc_w, bank_wdata[b]=req_wdata_w. If the bank had no grant at T, bank_en[b]=0 at T+1 and the other bank outputs hold.
- Read return:
  - At T+1 the block registers tag[b] = {valid = read, id = w}.
  - At T+2, rsp_valid[w]=1 and rsp_rdata_w = bank_rdata[b], one cycle pulse. rsp_rdata holds its last value otherwise.
  - Writes produce no response.
  - Total read latency: accept → rsp_valid = 2 cycles, fully pipelined. Each bank sustains one access per cycle.
- Simultaneous responses: distinct banks return to distinct requesters in the same cycle without conflict. A requester is never issued two reads landing in the same cycle, because it wins at most once per cycle.
- conflict_cnt: increments by 1 each cycle where any req_valid_i & !req_ready_i. Saturates at 2^32-1; no wrap.
- Reset mid-operation: in-flight commands and responses are discarded; no rsp_valid after reset deassertion for pre-reset reads.
- No backpressure from banks (banks always accept). No response backpressure: requesters must always sink rsp_valid.

Test Plan:
1. Reset with all req_valid=1 → req_ready=0, bank_en=0, conflict_cnt=0 during reset; after release, first-cycle grants follow rr_ptr=0.
2. Requesters 0..3 read addrs 0x0010, 0x0011, 0x0012, 0x0013 (banks 0..3) in one cycle → all ready; next cycle bank_en=4'b1111 with bank_addr=0x0004 each; 2 cycles after accept, rsp_valid=4'b1111 with each bank's data routed to the matching requester.
3. All four requesters hold valid to bank 2 (addrs 0x0002, 0x0006, 0x000A, 0x000E) → grants in order 0,1,2,3 over four cycles; conflict_cnt=3 afterwards; bank_addr sequence 0x0000, 0x0001, 0x0002, 0x0003.
4. Write 0xBEEF via req 1 to 0x0025, then read it via req 3 → bank_we[1]=1, bank_addr=0x0009, bank_wdata=0xBEEF; read returns 0xBEEF on rsp_rdata_3 only, with no rsp_valid for the write.
5. Back-to-back reads from req 0 to bank 1 for 8 cycles → 8 consecutive rsp_valid[0] pulses, 2-cycle latency, no bubbles.
6. Assert rst_n=0 one cycle after a read accept → no rsp_valid ever appears for it; rr_ptr returns to 0.

Source files
------------

// File: rtl/bank_request_scheduler.sv
// bank_request_scheduler: shares NB interleaved memory banks among NREQ
// requesters. Each bank has its own round-robin arbiter, issues at most one
// registered command per cycle, and read data is routed back to the winner
// two cycles after the request was accepted.
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is a pure function of the current
// requests and the per-bank round-robin pointers, never of its own past
// value. Requesters hold addr/we/wdata stable until accepted. Responses have
// no backpressure: rsp_valid is a one-cycle pulse that must be consumed.
module bank_request_scheduler #(
  parameter int ADDR_W = 16,
  parameter int NB     = 4,
  parameter int NREQ   = 4,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*DATA_W-1:0] rsp_rdata,
  output logic [NB-1:0]          bank_en,
  output logic [NB-1:0]          bank_we,
  output logic [NB*ADDR_W-1:0]   bank_addr,
  output logic [NB*DATA_W-1:0]   bank_wdata,
  input  logic [NB*DATA_W-1:0]   bank_rdata,
  output logic [31:0]            conflict_cnt
);

  localparam int BANK_BITS = (NB > 1) ? $clog2(NB) : 1;
  localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [BANK_BITS-1:0] sel      [NREQ];
  logic [ADDR_W-1:0]    loc      [NREQ];
  logic [ID_W-1:0]      rr_ptr   [NB];
  logic [NB-1:0]        gnt_any;
  logic [ID_W-1:0]      gnt_id   [NB];
  logic [NREQ-1:0]      grant;
  logic                 any_conflict;

  // read-return pipeline: tag per bank, then per-requester response select
  logic [NB-1:0]        tag_valid;
  logic [ID_W-1:0]      tag_id     [NB];
  logic [NREQ-1:0]      rsp_hit_d;
  logic [BANK_BITS-1:0] rsp_bank_d [NREQ];
  logic [BANK_BITS-1:0] rsp_bank_q [NREQ];
  logic [DATA_W-1:0]    rdata_hold [NREQ];

  // split each global address into bank select and local address
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      sel[i] = req_addr[i*ADDR_W +: BANK_BITS];
      loc[i] = req_addr[i*ADDR_W +: ADDR_W] >> BANK_BITS;
    end
  end

  // per-bank round-robin: first candidate scanning from rr_ptr upward
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    for (int b = 0; b < NB; b++) begin
      gnt_any[b] = 1'b0;
      gnt_id[b]  = '0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr[b]) + k) % NREQ;
        if (!gnt_any[b] && req_valid[idx] && (int'(sel[idx]) == b)) begin
          gnt_any[b] = 1'b1;
          gnt_id[b]  = ID_W'(idx);
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (gnt_any[b]) grant[gnt_id[b]] = 1'b1;
    end
  end

  // nothing is accepted while reset is asserted
  assign req_ready    = grant & {NREQ{rst_n}};
  assign any_conflict = |(req_valid & ~req_ready);

  // advance each bank's pointer past its winner; hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (gnt_any[b]) rr_ptr[b] <= ID_W'((int'(gnt_id[b]) + 1) % NREQ);
      end
    end
  end

  // register the winning command per bank; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_en    <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      tag_valid  <= '0;
      for (int b = 0; b < NB; b++) tag_id[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        bank_en[b]   <= gnt_any[b];
        tag_valid[b] <= gnt_any[b] & ~req_we[gnt_id[b]];
        if (gnt_any[b]) begin
          bank_we[b]                     <= req_we[gnt_id[b]];
          bank_addr[b*ADDR_W +: ADDR_W]  <= loc[gnt_id[b]];
          bank_wdata[b*DATA_W +: DATA_W] <= req_wdata[int'(gnt_id[b])*DATA_W +: DATA_W];
          tag_id[b]                      <= gnt_id[b];
        end
      end
    end
  end

  // map outstanding read tags onto the requesters they belong to
  always_comb begin
    rsp_hit_d = '0;
    for (int i = 0; i < NREQ; i++) rsp_bank_d[i] = '0;
    for (int b = 0; b < NB; b++) begin
      if (tag_valid[b]) begin
        rsp_hit_d[tag_id[b]]  = 1'b1;
        rsp_bank_d[tag_id[b]] = BANK_BITS'(b);
      end
    end
  end

  // response strobe and source-bank select, aligned with bank read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      for (int i = 0; i < NREQ; i++) rsp_bank_q[i] <= '0;
    end else begin
      rsp_valid <= rsp_hit_d;
      for (int i = 0; i < NREQ; i++) rsp_bank_q[i] <= rsp_bank_d[i];
    end
  end

  // bank data passes through on a response, otherwise the last value holds
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rsp_rdata[i*DATA_W +: DATA_W] = rsp_valid[i]
        ? bank_rdata[int'(rsp_bank_q[i])*DATA_W +: DATA_W]
        : rdata_hold[i];
    end
  end

  // capture the presented read data so it holds between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) rdata_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) rdata_hold[i] <= rsp_rdata[i*DATA_W +: DATA_W];
    end
  end

  // saturating count of cycles where some valid requester was not accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (any_conflict && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bank_request_scheduler.sv
// Directed testbench for bank_request_scheduler with a simple bank SRAM model.
module tb_bank_request_scheduler;

  localparam int ADDR_W = 16;
  localparam int NB     = 4;
  localparam int NREQ   = 4;
  localparam int DATA_W = 16;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ*DATA_W-1:0] rsp_rdata;
  logic [NB-1:0]          bank_en;
  logic [NB-1:0]          bank_we;
  logic [NB*ADDR_W-1:0]   bank_addr;
  logic [NB*DATA_W-1:0]   bank_wdata;
  logic [NB*DATA_W-1:0]   bank_rdata;
  logic [31:0]            conflict_cnt;

  int total;
  int bad;

  bank_request_scheduler #(
    .ADDR_W(ADDR_W), .NB(NB), .NREQ(NREQ), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // clock / reset-independent bank model: 1-cycle read latency
  logic [DATA_W-1:0] mem [NB][256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++)
        mem[b][a] = DATA_W'(16'h1000 * (b + 1) + a);
    bank_rdata = '0;
  end

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b])
          mem[b][bank_addr[b*ADDR_W +: 8]] <= bank_wdata[b*DATA_W +: DATA_W];
        else
          bank_rdata[b*DATA_W +: DATA_W] <= mem[b][bank_addr[b*ADDR_W +: 8]];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // single comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata);
    req_valid[i]                  = 1'b1;
    req_we[i]                     = we;
    req_addr[i*ADDR_W +: ADDR_W]  = addr;
    req_wdata[i*DATA_W +: DATA_W] = wdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_reqs();

    // 1: reset with every requester valid on bank 0
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 16'(4 * i), 16'h0);
    step();
    step();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_bank_en", 64'(bank_en), 64'h0);
    chk("rst_conflict", 64'(conflict_cnt), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(req_ready), 64'h1);
    step();
    chk("rel_bank_en", 64'(bank_en), 64'h1);
    chk("rel_bank_addr0", 64'(bank_addr[0 +: 16]), 64'h0);
    chk("rel_conflict", 64'(conflict_cnt), 64'h1);

    // 2: four reads to four banks in one cycle
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 16'(16'h0010 + i), 16'h0);
    #1;
    chk("par_ready", 64'(req_ready), 64'hF);
    step();
    clear_reqs();
    chk("par_bank_en", 64'(bank_en), 64'hF);
    chk("par_bank_we", 64'(bank_we), 64'h0);
    chk("par_bank_addr", 64'(bank_addr), 64'h0004_0004_0004_0004);
    chk("par_rsp_early", 64'(rsp_valid), 64'h0);
    step();
    chk("par_rsp_valid", 64'(rsp_valid), 64'hF);
    chk("par_rsp_rdata", 64'(rsp_rdata), 64'h4004_3004_2004_1004);
    step();
    chk("par_rsp_done", 64'(rsp_valid), 64'h0);
    chk("par_rsp_hold", 64'(rsp_rdata), 64'h4004_3004_2004_1004);
    chk("par_conflict", 64'(conflict_cnt), 64'h0);

    // 3: all requesters contend for bank 2
    do_reset();
    set_req(0, 1'b0, 16'h0002, 16'h0);
    set_req(1, 1'b0, 16'h0006, 16'h0);
    set_req(2, 1'b0, 16'h000A, 16'h0);
    set_req(3, 1'b0, 16'h000E, 16'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(1 << k));
      step();
      req_valid[k] = 1'b0;
      chk($sformatf("rr_bank_en%0d", k), 64'(bank_en), 64'h4);
      chk($sformatf("rr_bank_addr%0d", k), 64'(bank_addr[2*ADDR_W +: ADDR_W]), 64'(k));
      chk($sformatf("rr_rsp_valid%0d", k), 64'(rsp_valid),
          (k == 0) ? 64'h0 : 64'(1 << (k - 1)));
      if (k > 0)
        chk($sformatf("rr_rsp_rdata%0d", k), 64'(rsp_rdata[(k-1)*DATA_W +: DATA_W]),
            64'(16'h3000 + k - 1));
    end
    clear_reqs();
    chk("rr_conflict", 64'(conflict_cnt), 64'h3);

    // 4: write via requester 1, read back via requester 3
    do_reset();
    set_req(1, 1'b1, 16'h0025, 16'hBEEF);
    #1;
    chk("wr_ready", 64'(req_ready), 64'h2);
    step();
    clear_reqs();
    chk("wr_bank_en", 64'(bank_en), 64'h2);
    chk("wr_bank_we", 64'(bank_we), 64'h2);
    chk("wr_bank_addr", 64'(bank_addr[1*ADDR_W +: ADDR_W]), 64'h0009);
    chk("wr_bank_wdata", 64'(bank_wdata[1*DATA_W +: DATA_W]), 64'hBEEF);
    set_req(3, 1'b0, 16'h0025, 16'h0);
    #1;
    chk("rd_ready", 64'(req_ready), 64'h8);
    step();
    clear_reqs();
    chk("wr_no_rsp", 64'(rsp_valid), 64'h0);
    chk("rd_bank_we", 64'(bank_we), 64'h0);
    step();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'h8);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hBEEF_0000_0000_0000);

    // 5: back-to-back reads from requester 0 to bank 1
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) set_req(0, 1'b0, 16'(1 + 4 * k), 16'h0);
      else clear_reqs();
      #1;
      if (k < 8) chk($sformatf("b2b_ready%0d", k), 64'(req_ready), 64'h1);
      step();
      chk($sformatf("b2b_rsp_valid%0d", k), 64'(rsp_valid),
          (k >= 1 && k <= 8) ? 64'h1 : 64'h0);
      if (k >= 1 && k <= 8)
        chk($sformatf("b2b_rsp_rdata%0d", k), 64'(rsp_rdata[0 +: DATA_W]),
            64'(16'h2000 + k - 1));
    end

    // 6: reset one cycle after a read accept discards the read
    do_reset();
    set_req(0, 1'b0, 16'h0003, 16'h0);
    step();
    clear_reqs();
    chk("mid_bank_en", 64'(bank_en), 64'h8);
    rst_n = 1'b0;
    #1;
    chk("mid_bank_en_rst", 64'(bank_en), 64'h0);
    step();
    chk("mid_rsp_rst", 64'(rsp_valid), 64'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mid_rsp_after%0d", k), 64'(rsp_valid), 64'h0);
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 16'(4 * i + 3), 16'h0);
    #1;
    chk("mid_ptr_zero", 64'(req_ready), 64'h1);
    step();
    clear_reqs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
